// File: rtl/local_mem_reader_pkg.sv
// Shared constants and state encoding for the local memory reader.
package local_mem_reader_pkg;

  // Default geometry: 1K-word memory of 32-bit words, requests of 0..1024 words.
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LEN_W      = 11;

  // Output buffering; also the bound on words buffered plus reads in flight.
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/lmr_fifo2.sv
// Two-entry output FIFO with a registered head; occupancy exported as a count.
module lmr_fifo2 #(
  parameter int unsigned WIDTH = 33
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    push,
  input  logic [WIDTH-1:0]                        push_data,
  input  logic                                    pop,
  output logic [local_mem_reader_pkg::CNT_W-1:0]  count,
  output logic [WIDTH-1:0]                        head
);

  import local_mem_reader_pkg::*;

  logic [WIDTH-1:0] mem_q [2];
  logic             wptr_q;
  logic             rptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push_ok;
  logic             pop_ok;

  // Guard against overflow/underflow; a push into a full FIFO is only taken with a pop.
  always_comb begin
    pop_ok  = pop && (count_q != '0);
    push_ok = push && ((count_q != CNT_W'(FIFO_DEPTH)) || pop_ok);
  end

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy; everything clears on reset so head reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= ~wptr_q;
      end
      if (pop_ok) begin
        rptr_q <= ~rptr_q;
      end
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rptr_q];

endmodule

// File: rtl/local_mem_reader.sv
// Streams a block of words out of a one-cycle-latency local memory.
// Reads are throttled so that buffered words plus reads in flight never exceed
// the FIFO depth, which lets the stream back-pressure without dropping data.
module local_mem_reader #(
  parameter int unsigned ADDR_W = local_mem_reader_pkg::ADDR_W,
  parameter int unsigned DATA_W = local_mem_reader_pkg::DATA_W,
  parameter int unsigned LEN_W  = local_mem_reader_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  // Request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  // Local memory
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  // Stream
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  // Status
  output logic              busy,
  output logic              done
);

  import local_mem_reader_pkg::*;

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_d;
  logic              done_q;
  logic              done_d;
  // A read issued last cycle; its data is on mem_dout this cycle.
  logic              rd_pend_q;
  logic              rd_last_q;

  logic              rd_issue;
  logic              rd_final;
  logic [2:0]        occ;

  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W:0]   fifo_wdata;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W:0]   fifo_head;

  // Each FIFO entry carries its data word plus an end-of-request marker.
  assign fifo_push  = rd_pend_q;
  assign fifo_wdata = {rd_last_q, mem_dout};
  assign fifo_pop   = m_valid && m_ready;

  lmr_fifo2 #(
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Stream side follows the FIFO head directly, so it is stable under back-pressure.
  always_comb begin
    m_valid = (fifo_count != '0);
    m_data  = fifo_head[DATA_W-1:0];
    m_last  = m_valid && fifo_head[DATA_W];
  end

  // Issue a read only if the slot it will land in is guaranteed free.
  always_comb begin
    occ      = 3'(fifo_count) + 3'(rd_pend_q) - 3'(fifo_pop);
    rd_issue = (state_q == StRead) && (occ < 3'(FIFO_DEPTH));
    rd_final = rd_issue && (len_q == LEN_W'(1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && (req_len != '0)) begin
          state_d = StRead;
        end
      end
      StRead: begin
        if (rd_final) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_pop && m_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle:          req_ready = 1'b1;
      StRead, StDrain: busy      = 1'b1;
      default:         req_ready = 1'b0;
    endcase
  end

  // Address/length counters and the completion pulse.
  always_comb begin
    addr_d = addr_q;
    len_d  = len_q;
    done_d = 1'b0;
    if ((state_q == StIdle) && req_valid) begin
      if (req_len == '0) begin
        done_d = 1'b1;
      end else begin
        addr_d = req_addr;
        len_d  = req_len;
      end
    end
    if (rd_issue) begin
      // Address wraps naturally at the top of the memory.
      addr_d = addr_q + ADDR_W'(1);
      len_d  = len_q - LEN_W'(1);
    end
    if ((state_q == StDrain) && fifo_pop && m_last) begin
      done_d = 1'b1;
    end
  end

  // Datapath registers; reset drops any read in flight so its data is never pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      len_q     <= len_d;
      done_q    <= done_d;
      rd_pend_q <= rd_issue;
      rd_last_q <= rd_final;
    end
  end

  assign mem_we   = 1'b0;
  assign mem_din  = '0;
  assign mem_addr = addr_q;
  assign done     = done_q;

endmodule

// File: tb/tb_local_mem_reader.sv
// Directed bench for local_mem_reader with a one-cycle-latency memory model
// whose data word equals its address.
module tb_local_mem_reader;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_addr;
  logic [10:0] req_len;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  local_mem_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: data = address, available one cycle after the address is sampled.
  always @(posedge clk) mem_dout <= 32'(mem_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Observation state, reset at the start of each tracked transfer.
  bit          trk = 1'b0;
  logic [9:0]  trk_start;
  int          trk_pops;
  int          occ_v;
  int          max_occ;
  int          first_valid_cyc;
  int          done_cnt;
  int          done_cyc;
  int          c1;
  bit          any_valid;
  bit          any_busy;
  bit          ready_busy_bad;
  logic [31:0] got_data [$];
  bit          got_last [$];
  int          pop_cyc  [$];
  logic [9:0]  addr_hist[$];

  always @(negedge clk) begin
    if (trk) begin
      addr_hist.push_back(mem_addr);
      // Words issued so far minus words popped = buffered plus in flight.
      occ_v = int'(10'(mem_addr - trk_start)) - trk_pops;
      if (occ_v > max_occ) max_occ = occ_v;
      if (m_valid) begin
        any_valid = 1'b1;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (busy) any_busy = 1'b1;
      if (busy && req_ready) ready_busy_bad = 1'b1;
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
        pop_cyc.push_back(cyc);
        trk_pops++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_track(input logic [9:0] a);
    got_data.delete();
    got_last.delete();
    pop_cyc.delete();
    addr_hist.delete();
    trk_start       = a;
    trk_pops        = 0;
    max_occ         = 0;
    first_valid_cyc = -1;
    done_cnt        = 0;
    done_cyc        = -1;
    any_valid       = 1'b0;
    any_busy        = 1'b0;
    ready_busy_bad  = 1'b0;
    c1              = cyc;
    trk             = 1'b1;
  endtask

  // Offer one request while idle; returns 1 ns into the first cycle after acceptance.
  task automatic send(input logic [9:0] a, input logic [10:0] l);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    start_track(a);
  endtask

  // Wait (bounded) for done; returns at the negedge where done is seen.
  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_seq(input string tag, input logic [9:0] a, input int n);
    check_val({tag, "_count"}, 32'(got_data.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s_data%0d", tag, i), got_data[i], 32'(10'(a + 10'(i))));
      check_val($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    m_ready   = 1'b1;

    // Reset values.
    repeat (2) @(negedge clk);
    check_val("rst_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_busy",      32'(busy),      32'd0);
    check_val("rst_done",      32'(done),      32'd0);
    check_val("rst_m_valid",   32'(m_valid),   32'd0);
    check_val("rst_m_last",    32'(m_last),    32'd0);
    check_val("rst_m_data",    m_data,         32'd0);
    check_val("rst_mem_addr",  32'(mem_addr),  32'd0);
    check_val("rst_mem_we",    32'(mem_we),    32'd0);
    check_val("rst_mem_din",   mem_din,        32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic transfer: latency, back-to-back words, single done.
    send(10'h010, 11'd4);
    wait_done("t1", 50);
    repeat (3) @(negedge clk);
    check_seq("t1", 10'h010, 4);
    check_val("t1_first_valid_lat", 32'(first_valid_cyc - c1), 32'd2);
    check_val("t1_back_to_back",    32'(pop_cyc[3] - pop_cyc[0]), 32'd3);
    check_val("t1_done_cnt",        32'(done_cnt), 32'd1);
    check_val("t1_busy_after",      32'(busy), 32'd0);
    check_val("t1_mem_we",          32'(mem_we), 32'd0);

    // Address wrap at the top of memory.
    send(10'h3FE, 11'd4);
    wait_done("t2", 50);
    repeat (2) @(negedge clk);
    check_val("t2_addr0", 32'(addr_hist[0]), 32'h3FE);
    check_val("t2_addr1", 32'(addr_hist[1]), 32'h3FF);
    check_val("t2_addr2", 32'(addr_hist[2]), 32'h000);
    check_val("t2_addr3", 32'(addr_hist[3]), 32'h001);
    check_seq("t2", 10'h3FE, 4);

    // Back-pressure: m_ready low for cycles 5..10 after acceptance.
    send(10'h200, 11'd16);
    fork
      begin
        for (int k = 1; k <= 12; k++) begin
          m_ready = !(k >= 5 && k <= 10);
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
    join_none
    wait_done("t3", 200);
    repeat (2) @(negedge clk);
    check_val("t3_addr_stall6",  32'(addr_hist[5]),  32'h204);
    check_val("t3_addr_stall10", 32'(addr_hist[9]),  32'h204);
    check_val("t3_addr_resume",  32'(addr_hist[11]), 32'h205);
    check_val("t3_max_outstanding", 32'(max_occ), 32'd2);
    check_seq("t3", 10'h200, 16);
    check_val("t3_done_cnt", 32'(done_cnt), 32'd1);

    // Zero-length request.
    send(10'h050, 11'd0);
    repeat (5) @(negedge clk);
    check_val("t4_done_cnt",  32'(done_cnt), 32'd1);
    check_val("t4_done_cyc",  32'(done_cyc - c1), 32'd0);
    check_val("t4_no_valid",  32'(any_valid), 32'd0);
    check_val("t4_no_busy",   32'(any_busy), 32'd0);

    // req_valid held through a transfer, then a second request.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = 10'h300;
    req_len   = 11'd3;
    @(posedge clk);
    #1;
    start_track(10'h300);
    wait_done("t5a", 50);
    check_val("t5_ready_at_done", 32'(req_ready), 32'd1);
    check_val("t5_ready_low_busy", 32'(ready_busy_bad), 32'd0);
    check_seq("t5a", 10'h300, 3);
    req_addr = 10'h100;
    req_len  = 11'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    start_track(10'h100);
    wait_done("t5b", 50);
    repeat (3) @(negedge clk);
    check_seq("t5b", 10'h100, 2);
    check_val("t5b_done_cnt", 32'(done_cnt), 32'd1);

    // Reset mid-transfer abandons it.
    send(10'h180, 11'd8);
    repeat (3) @(posedge clk);
    #1;
    rst_n    = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    check_val("t6_rst_busy",     32'(busy),     32'd0);
    check_val("t6_rst_m_valid",  32'(m_valid),  32'd0);
    check_val("t6_rst_m_last",   32'(m_last),   32'd0);
    check_val("t6_rst_m_data",   m_data,        32'd0);
    check_val("t6_rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("t6_rst_done",     32'(done),     32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    any_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_val("t6_no_done",     32'(done_cnt),  32'd0);
    check_val("t6_no_stale",    32'(any_valid), 32'd0);
    check_val("t6_ready_after", 32'(req_ready), 32'd1);
    send(10'h020, 11'd3);
    wait_done("t6", 50);
    repeat (3) @(negedge clk);
    check_seq("t6", 10'h020, 3);
    check_val("t6_done_cnt", 32'(done_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
